// File: rtl/jzjpcc_fetch_pkg.sv
// Shared types and helpers for the jzjpcc instruction-fetch stage.
package jzjpcc_fetch_pkg;

  typedef enum logic {RUN, HALTED} fetch_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_MISALIGNED = 2'd1,
    FAULT_RANGE      = 2'd2,
    FAULT_OVERFLOW   = 2'd3
  } fetch_fault_t;

  // The backend drops the low two bits; RV32 base instructions always have them set.
  localparam logic [1:0] INSTR_LOW_BITS = 2'b11;

  // Highest word-aligned implemented byte address for a given top PC bit.
  function automatic logic [31:0] pcMax(input int pc_max_b);
    logic [32:0] span;
    span = 33'd1 << (pc_max_b + 1);
    return 32'(span - 33'd4);
  endfunction

endpackage

// File: rtl/jzjpcc_pc_fault_check.sv
// Combinational classification of illegal fetch targets for the current cycle.
module jzjpcc_pc_fault_check
  import jzjpcc_fetch_pkg::*;
#(
  parameter int PC_MAX_B = 11
) (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_fetch,
  output logic        fault,
  output logic [1:0]  code
);

  localparam logic [31:0] PC_MAX = pcMax(PC_MAX_B);

  // Misalignment outranks range; a sequential overflow only matters when actually stepping.
  always_comb begin
    fault = 1'b0;
    code  = FAULT_NONE;
    if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        fault = 1'b1;
        code  = FAULT_MISALIGNED;
      end else if (redirect_pc > PC_MAX) begin
        fault = 1'b1;
        code  = FAULT_RANGE;
      end else begin
        fault = 1'b0;
        code  = FAULT_NONE;
      end
    end else if (!stall_fetch && (pc == PC_MAX)) begin
      fault = 1'b1;
      code  = FAULT_OVERFLOW;
    end else begin
      fault = 1'b0;
      code  = FAULT_NONE;
    end
  end

endmodule

// File: rtl/jzjpcc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle-latency SRAM address,
// and presents {instruction, pc, valid} to decode with sticky fault halting.
module jzjpcc_fetch_stage
  import jzjpcc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_MAX_B = 11
) (
  input  logic               clock,
  input  logic               reset,
  output logic [PC_MAX_B:2]  instructionAddressToLatch,
  input  logic [31:2]        instruction_fetch,
  input  logic               stall_fetch,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        instruction_decode,
  output logic [31:0]        pc_decode,
  output logic               valid_decode,
  output logic               fetch_fault,
  output logic [1:0]         fault_code
);

  localparam logic [PC_MAX_B:2] WORD_STEP = {{(PC_MAX_B-2){1'b0}}, 1'b1};

  fetch_state_t       state;
  logic [PC_MAX_B:2]  pc_word;
  logic [PC_MAX_B:2]  next_word;
  logic [31:0]        pc_full;
  logic               chk_fault;
  logic [1:0]         chk_code;
  logic               fault_now;

  always_comb begin
    pc_full             = 32'd0;
    pc_full[PC_MAX_B:2] = pc_word;
  end

  jzjpcc_pc_fault_check #(.PC_MAX_B(PC_MAX_B)) u_fault_check (
    .pc             (pc_full),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_fetch    (stall_fetch),
    .fault          (chk_fault),
    .code           (chk_code)
  );

  assign fault_now = (state == RUN) && chk_fault;

  // A faulting cycle freezes the PC just like HALTED does, so the SRAM keeps re-reading it.
  always_comb begin
    next_word = pc_word;
    if (reset) begin
      next_word = RESET_PC[PC_MAX_B:2];
    end else if ((state == HALTED) || fault_now) begin
      next_word = pc_word;
    end else if (redirect_valid) begin
      next_word = redirect_pc[PC_MAX_B:2];
    end else if (stall_fetch) begin
      next_word = pc_word;
    end else begin
      next_word = pc_word + WORD_STEP;
    end
  end

  assign instructionAddressToLatch = next_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      pc_word     <= RESET_PC[PC_MAX_B:2];
      fetch_fault <= 1'b0;
      fault_code  <= FAULT_NONE;
    end else begin
      pc_word <= next_word;
      if (fault_now) begin
        state       <= HALTED;
        fetch_fault <= 1'b1;
        fault_code  <= chk_code;
      end
    end
  end

  // SRAM output is already registered, so decode sees it directly.
  assign instruction_decode = {instruction_fetch, INSTR_LOW_BITS};
  assign pc_decode          = pc_full;
  assign valid_decode       = !reset && (state == RUN);

endmodule
